// File: rtl/disto16x16_seq.sv
// Macroblock distortion sequencer: walks the 16 4x4 sub-blocks of a latched
// 16x16 pair through one disto4x4 engine and saturating-accumulates the sums.
module disto16x16_seq #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2047:0] src_a,
  input  logic [2047:0] src_b,
  input  logic [255:0]  w,
  output logic          busy,
  output logic [31:0]   sum,
  output logic          done,
  output logic          err,
  output logic          d_start,
  output logic [127:0]  d_ina,
  output logic [127:0]  d_inb,
  output logic [255:0]  d_w,
  input  logic [31:0]   d_sum,
  input  logic          d_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [3:0]     k_q, k_d;
  logic [31:0]    acc_q, acc_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [31:0]    sum_q, sum_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           busy_q;
  logic           d_start_q;
  logic           capture_s;
  logic [2047:0]  a_q, b_q;
  logic [255:0]   w_q;
  logic [1:0]     row_s, col_s;

  // Unsigned add that clamps to all-ones on carry-out.
  function automatic logic [31:0] sat_add(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign row_s = k_q[3:2];
  assign col_s = k_q[1:0];

  // Gather pixel (4r+i, 4c+j) of each captured block into the sub-block buses.
  always_comb begin
    d_ina = '0;
    d_inb = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        d_ina[8*(4*i+j) +: 8] = a_q[8*(16*(4*int'(row_s)+i) + 4*int'(col_s) + j) +: 8];
        d_inb[8*(4*i+j) +: 8] = b_q[8*(16*(4*int'(row_s)+i) + 4*int'(col_s) + j) +: 8];
      end
    end
  end

  // Next-state and result logic.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    done_d    = 1'b0;
    err_d     = err_q;
    capture_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          capture_s = 1'b1;
          k_d       = 4'd0;
          acc_d     = 32'd0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (d_done) begin
          acc_d = sat_add(acc_q, d_sum);
          if (k_q == 4'd15) begin
            sum_d   = acc_d;
            done_d  = 1'b1;
            err_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = S_ISSUE;
          end
        end else if (cnt_q == TO_LAST) begin
          sum_d   = acc_q;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; busy/d_start look ahead at the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= 4'd0;
      acc_q     <= 32'd0;
      cnt_q     <= 8'd0;
      sum_q     <= 32'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      d_start_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= (state_d != S_IDLE);
      d_start_q <= (state_d == S_ISSUE);
    end
  end

  // Operand capture on the accepting edge.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      a_q <= src_a;
      b_q <= src_b;
      w_q <= w;
    end
  end

  assign busy    = busy_q;
  assign sum     = sum_q;
  assign done    = done_q;
  assign err     = err_q;
  assign d_start = d_start_q;
  assign d_w     = w_q;

endmodule

// File: doc/disto16x16_seq.md
# disto16x16_seq

Sequencer for the 16x16 macroblock distortion in the mode-decision path. It latches two 16x16 luma blocks and a 4x4 weight set, then walks the 16 sub-blocks in raster order. For each sub-block it drives one `disto4x4` instance through its start/done handshake and accumulates the returned per-block sums into a single 32-bit macroblock distortion.

## Interface

Parameters:
- `TIMEOUT`, default 15: maximum cycles spent in WAIT per sub-block before aborting; legal range 4..255.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  single-cycle request; sampled only in IDLE
- `src_a`  in  2048  block A; pixel (y,x) at bits [8*(16y+x) +: 8]
- `src_b`  in  2048  block B; same layout
- `w`  in  256  16 x 16-bit weights, forwarded unchanged
- `busy`  out  1  high in any state other than IDLE
- `sum`  out  32  macroblock distortion; held until the next `done`
- `done`  out  1  one-cycle pulse; `sum`/`err` are valid in that cycle
- `err`  out  1  valid with `done`; 1 = aborted on timeout
- `d_start`  out  1  start strobe to `disto4x4`
- `d_ina`  out  128  sub-block of A; pixel (i,j) at bits [8*(4i+j) +: 8]
- `d_inb`  out  128  sub-block of B; same layout
- `d_w`  out  256  copy of latched `w`
- `d_sum`  in  32  `disto4x4` result
- `d_done`  in  1  `disto4x4` result strobe

## Operation

- `src_a`, `src_b` and `w` are captured into internal registers on the accepting edge. The inputs may change freely afterwards.
- Sub-block index k runs 0..15. Row r = k>>2, column c = k&3.
- `d_ina` pixel (i,j) = captured A pixel (4r+i, 4c+j); `d_inb` is built the same way from B.
- `d_ina`, `d_inb` and `d_w` are combinational from the captured registers and k. They stay stable from ISSUE until the matching `d_done`.
- FSM states:
  - IDLE: when `start`=1, capture inputs, set k=0, acc=0, go to ISSUE.
  - ISSUE: `d_start`=1 for exactly this cycle; go to WAIT with wait counter = 0.
  - WAIT, `d_done`=1: acc <= sat(acc + `d_sum`).
    - If k=15: `sum` <= sat(acc + `d_sum`), `done`=1, `err`=0, go to IDLE.
    - Otherwise: k++, go to ISSUE.
  - WAIT, no `d_done`, counter = TIMEOUT-1: `sum` <= acc, `done`=1, `err`=1, go to IDLE.
  - WAIT, otherwise: counter++.
- Arithmetic:
  - acc is 32-bit unsigned.
  - sat() clamps to 0xFFFFFFFF on carry-out. Once saturated, acc stays saturated.
- Boundary conditions:
  - `start` outside IDLE is ignored; nothing is queued.
  - `d_done` outside WAIT is ignored.
  - `d_sum` is sampled only in a WAIT cycle with `d_done`=1.
  - `start` in the same cycle as `done` is accepted, because the FSM is already in IDLE.
  - `rst` mid-operation: the FSM returns to IDLE on the next edge and the in-flight result is discarded.

## Timing

- Reset values: `sum`=0, `done`=0, `err`=0, `busy`=0, `d_start`=0, state=IDLE, k=0, acc=0.
- Cycle numbering uses the edge that samples `start` as edge 0.
- Sub-block k: ISSUE occupies cycle 1+4k; with `disto4x4` latency 3, `d_done` arrives in cycle 4+4k.
- `done` is high in cycle 65. Total latency is 65 cycles; next `start` can be accepted at the end of cycle 65.
- For a general `disto4x4` latency L (cycles from `d_start` to `d_done`), `done` is high in cycle 16(L+1)+1.
- `busy` goes high in cycle 1 and low in the cycle where `done` is high.
- All outputs are registered, except `d_ina`/`d_inb`/`d_w`.
- `d_start` is a registered output that is high exactly during ISSUE.

## Test plan

- `src_a` = `src_b` = random, `disto4x4` instantiated -> `done` high in cycle 65, `sum`=0, `err`=0, exactly 16 `d_start` pulses.
- Stub `disto4x4` returning `d_sum` = k+1 at latency 3 -> `sum`=136, `err`=0.
- Same stub, also checking each `d_ina`/`d_inb` against expected pixels -> pixel (i,j) of block k equals A/B pixel (4(k>>2)+i, 4(k&3)+j).
- Stub returning 0x20000000 for every block -> `sum`=0xFFFFFFFF, `err`=0.
- Stub never asserting `d_done`, TIMEOUT=15 -> `done` and `err`=1 in cycle 17, `sum`=0.
- `start` asserted again in cycle 10 -> ignored, `done` still in cycle 65.
- `rst` in cycle 20 then a new `start` -> fresh run; `done` at cycle 65 relative to the new start edge.
- Stub with `d_done` and a spurious `d_done` in IDLE -> no state change.
